uart_tx_scheduler: RTL
======================

# uart_tx_scheduler

Shares the single UART transmitter among three byte sources: echoed command characters, command-response packets, and acquisition-data packets. Sits between the UART receiver/command decoder, the echo-enable FSM, the acquisition readout, and the UART TX core. Owns the TX start/busy handshake and keeps multi-byte packets contiguous on the serial line.

## Interface
- No parameters. Widths are fixed at 8-bit bytes.
- Clock  in  1  system clock; every register is clocked on its rising edge.
- Reset  in  1  synchronous, active-high.
- RxData  in  8  byte from the UART receiver.
- RxValid  in  1  one-cycle pulse when RxData is new.
- EchoEn  in  1  level from the echo-enable FSM; 1 means received bytes are echoed.
- RespData  in  8, RespValid  in  1, RespLast  in  1, RespReady  out  1  response packet stream.
- DataData  in  8, DataValid  in  1, DataLast  in  1, DataReady  out  1  acquisition packet stream.
- TxData  out  8  byte presented to the UART TX core.
- TxStart  out  1  one-cycle pulse that starts transmission of TxData.
- TxBusy  in  1  UART TX core busy; rises 1 cycle after TxStart and falls when the stop bit ends.
- EchoOverrun  out  1  sticky flag: an echo byte was dropped. Cleared only by Reset.

## Operation
- Echo buffer is a single entry. It captures RxData when RxValid=1 and EchoEn=1.
  - If the buffer is already full when such a capture arrives, the new byte is dropped and EchoOverrun is set.
  - EchoEn is sampled only at the moment of capture. Clearing EchoEn does not flush an already-held byte.
- Stream transfer: a byte moves when Valid&Ready=1 in the same cycle. Ready is combinational.
  - Ready is 1 only in IDLE, only for the selected source, and only while Reset=0.
  - A source holds Data, Valid and Last stable until it sees Ready.
- Arbitration happens in IDLE.
  - If lock=NONE, the fixed priority is echo > resp > data.
  - If lock=RESP or lock=DATA, only the locked source is eligible. A pending echo waits.
- Lock update on each stream transfer:
  - Last=0 sets lock to that source.
  - Last=1 clears lock to NONE.
  - A single-byte packet (Last=1 on its first byte) never sets the lock.
- The FSM has four states: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE.
  - IDLE→LAUNCH when a source is selected. The byte is latched into TxData and, for echo, the buffer is emptied.
  - LAUNCH: TxStart=1 for exactly this one cycle, then go to WAIT_ACK.
  - WAIT_ACK: wait for TxBusy=1, then go to WAIT_DONE.
  - WAIT_DONE: wait for TxBusy=0, then go to IDLE.
- If RxValid arrives in the same cycle the buffer is emptied, the new byte is captured with no overrun.
- TxBusy=1 seen while in IDLE is ignored. No source is selected until TxBusy=0.

## Timing
- Reset values: state IDLE, TxStart=0, TxData=0x00, EchoOverrun=0, echo buffer empty, lock NONE, RespReady=DataReady=0.
- Reset asserted in any state returns to IDLE on the next edge. An in-flight byte is abandoned, and a held echo byte and the lock are discarded.
- Latency, echo path: RxValid in cycle n (IDLE, TX idle) → TxStart in cycle n+2 (capture at n, select at n+1, LAUNCH at n+2).
- Latency, stream path: a transfer in cycle n → TxStart in cycle n+1.
- Back-to-back bytes: TxBusy falls in cycle m → next TxStart no earlier than m+2.
- TxData stays stable from LAUNCH until the next IDLE→LAUNCH transition.

## Configuration
- ECHO_CRLF_EN defined:
  - When an echoed byte equals 0x0D (CR), the echo buffer immediately queues 0x0A (LF) after it.
  - The CR/LF pair is contiguous: echo is locked until the LF is sent.
  - An RxValid arriving while the LF is pending counts as an overrun.
- ECHO_CRLF_EN undefined: every byte is echoed exactly once, with no insertion.

## Structure
- Package uart_tx_sched_pkg holds:
  - the state enum (IDLE, LAUNCH, WAIT_ACK, WAIT_DONE);
  - the source/lock encoding (NONE, ECHO, RESP, DATA);
  - the constants CHAR_CR=8'h0D and CHAR_LF=8'h0A.
- One sub-module, uart_tx_echo_buf, contains:
  - the single-entry echo buffer;
  - the overrun flag;
  - the CR→LF insertion under ECHO_CRLF_EN.
- The top level contains the arbiter, the lock register and the FSM.

## Test plan
- Basic echo: EchoEn=1, RxValid with 0x41, TX model idle → TxStart 2 cycles later with TxData=0x41; exactly one TxStart.
- Overrun: EchoEn=1, send 0x31 then 0x32 while TxBusy=1 → only 0x31 transmitted; EchoOverrun=1 and it stays 1 until Reset.
- Packet lock: response packet 0x4F,0x4B(Last) is in flight; inject echo 0x65 after its first byte → serial order 0x4F,0x4B,0x65.
- Priority: echo, resp and data all pending in IDLE with lock NONE → order echo, resp byte, data byte; RespReady and DataReady are never both 1.
- CRLF: with ECHO_CRLF_EN defined, echo 0x0D → TxData 0x0D then 0x0A. Without ECHO_CRLF_EN → only 0x0D.
- Reset mid-packet: assert Reset during WAIT_DONE of data byte 2 of 4 → next cycle IDLE, TxStart=0, lock NONE. After release, a pending echo is not blocked by the old data lock.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: shared types and constants for the UART TX scheduler.
// Holds the FSM state enum, the source/lock encoding and the CR/LF characters.
package uart_tx_sched_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT_ACK, ST_WAIT_DONE} state_e;
  typedef enum logic [1:0] {SRC_NONE, SRC_ECHO, SRC_RESP, SRC_DATA} src_e;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;
endpackage

// File: rtl/uart_tx_echo_buf.sv
// uart_tx_echo_buf: single-entry echo buffer with sticky overrun flag.
// Ports: Clock/Reset (sync, active-high); rx_data_i/rx_valid_i/echo_en_i capture a
// received byte; pop_i empties the entry; echo_valid_o/echo_data_o/echo_last_o present
// the held byte (echo_last_o=0 means a follow-on byte is queued); echo_overrun_o is sticky.
// ECHO_CRLF_EN: when defined, popping a CR immediately refills the entry with LF.
module uart_tx_echo_buf
  import uart_tx_sched_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  input  logic       echo_en_i,
  input  logic       pop_i,
  output logic       echo_valid_o,
  output logic [7:0] echo_data_o,
  output logic       echo_last_o,
  output logic       echo_overrun_o
);
  logic       full_q, full_d, ovr_q, ovr_d, cap, refill, keep;
  logic [7:0] data_q, data_d;
  assign cap = rx_valid_i & echo_en_i;
`ifdef ECHO_CRLF_EN
  assign refill      = pop_i & (data_q == CHAR_CR);
  assign echo_last_o = data_q != CHAR_CR;
`else
  assign refill      = 1'b0;
  assign echo_last_o = 1'b1;
`endif
  // Entry is still occupied after this cycle: not popped, or popped CR turning into LF.
  // A capture into an entry freed this same cycle is accepted without overrun.
  assign keep   = full_q & (~pop_i | refill);
  assign full_d = keep | cap;
  assign data_d = refill ? CHAR_LF : (cap & ~keep) ? rx_data_i : data_q;
  assign ovr_d  = ovr_q | (cap & keep);
  always_ff @(posedge Clock) begin
    if (Reset) begin
      full_q <= 1'b0;
      data_q <= 8'h00;
      ovr_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      ovr_q  <= ovr_d;
    end
  end
  assign echo_valid_o   = full_q;
  assign echo_data_o    = data_q;
  assign echo_overrun_o = ovr_q;
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmitter among echo, response and data sources.
// Ports: Clock/Reset (sync, active-high); RxData/RxValid/EchoEn feed the echo buffer;
// Resp*/Data* are valid/ready byte streams with Last marking packet end; TxData/TxStart/
// TxBusy form the TX core handshake; EchoOverrun is a sticky dropped-echo flag.
// ECHO_CRLF_EN: when defined, an echoed CR is followed contiguously by an LF.
module uart_tx_scheduler
  import uart_tx_sched_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] RxData,
  input  logic       RxValid,
  input  logic       EchoEn,
  input  logic [7:0] RespData,
  input  logic       RespValid,
  input  logic       RespLast,
  output logic       RespReady,
  input  logic [7:0] DataData,
  input  logic       DataValid,
  input  logic       DataLast,
  output logic       DataReady,
  output logic [7:0] TxData,
  output logic       TxStart,
  input  logic       TxBusy,
  output logic       EchoOverrun
);
  state_e     state_q;
  src_e       lock_q, lock_d;
  logic [7:0] tx_data_q, tx_data_d, echo_data;
  logic       tx_start_q, echo_valid, echo_last;
  logic       idle_ok, free, echo_go, resp_go, data_go, go;

  uart_tx_echo_buf u_echo (
    .Clock         (Clock),
    .Reset         (Reset),
    .rx_data_i     (RxData),
    .rx_valid_i    (RxValid),
    .echo_en_i     (EchoEn),
    .pop_i         (echo_go),
    .echo_valid_o  (echo_valid),
    .echo_data_o   (echo_data),
    .echo_last_o   (echo_last),
    .echo_overrun_o(EchoOverrun)
  );

  // Busy seen in IDLE holds off selection until the TX core is really free.
  assign idle_ok   = (state_q == ST_IDLE) & ~TxBusy & ~Reset;
  assign free      = lock_q == SRC_NONE;
  assign echo_go   = idle_ok & echo_valid & (free | (lock_q == SRC_ECHO));
  // Resp is offered only when it has a byte, so data can be the selected source otherwise.
  assign RespReady = idle_ok & ((free & ~echo_valid & RespValid) | (lock_q == SRC_RESP));
  assign DataReady = idle_ok & ((free & ~echo_valid & ~RespValid) | (lock_q == SRC_DATA));
  assign resp_go   = RespReady & RespValid;
  assign data_go   = DataReady & DataValid;
  assign go        = echo_go | resp_go | data_go;
  assign tx_data_d = echo_go ? echo_data : resp_go ? RespData : DataData;
  assign lock_d    = echo_go ? (echo_last ? SRC_NONE : SRC_ECHO) :
                     resp_go ? (RespLast ? SRC_NONE : SRC_RESP) :
                               (DataLast ? SRC_NONE : SRC_DATA);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      lock_q     <= SRC_NONE;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (go) begin
          state_q    <= ST_LAUNCH;
          tx_start_q <= 1'b1;
          tx_data_q  <= tx_data_d;
          lock_q     <= lock_d;
        end
        ST_LAUNCH:    state_q <= ST_WAIT_ACK;
        ST_WAIT_ACK:  if (TxBusy) state_q <= ST_WAIT_DONE;
        ST_WAIT_DONE: if (!TxBusy) state_q <= ST_IDLE;
        default:      state_q <= ST_IDLE;
      endcase
    end
  end

  assign TxData  = tx_data_q;
  assign TxStart = tx_start_q;
endmodule
